// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial bit-sequence detector with arm/disarm
// sequencing, saturating match counter and completion flag.
//
// state | meaning
// IDLE  | disarmed, config writable, match_cnt holds last run's result
// RUN   | armed, bits shift into history, matches counted, out pulses
// DONE  | target reached, detection frozen until start or stop
module seq_detect_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [MAX_LEN-1:0]           cfg_pat,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_ovl,
   input  logic [CNT_W-1:0]             cfg_target,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         in_valid,
   input  logic                         in,
   output logic                         out,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         busy,
   output logic                         done,
   output logic                         cfg_err
);

   localparam int LEN_W = $clog2(MAX_LEN+1);
   localparam int LW1   = LEN_W + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic [CNT_W-1:0]   target_q;

   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic [CNT_W-1:0]   match_cnt_q;
   logic               done_q;
   logic               cfg_err_q;

   logic [MAX_LEN-1:0] window;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill_inc;
   logic [LEN_W-1:0]   eff_len;
   logic [CNT_W-1:0]   cnt_inc;
   logic               cnt_sat;
   logic               fill_ok;
   logic               match;
   logic               cfg_ok;
   logic               hit_target;
   logic               launch;
   logic               done_d;
   logic               cfg_err_d;

   // Newest bit sits at bit 0, so the pattern's last bit lines up with pat[0].
   assign window = {hist_q[MAX_LEN-2:0], in};

   // Only the low len bits of the window take part in the compare.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
   end

   assign fill_ok  = ({1'b0, fill_q} + LW1'(1)) >= {1'b0, len_q};
   assign match    = in_valid && fill_ok && (((window ^ pat_q) & len_mask) == '0);
   assign out      = match && (state_q == RUN);

   assign fill_inc = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
   assign cnt_sat  = (match_cnt_q == CNT_MAX);
   assign cnt_inc  = cnt_sat ? match_cnt_q : match_cnt_q + CNT_W'(1);

   // A saturated counter never "reaches" the target again.
   assign hit_target = (target_q != '0) && !cnt_sat && (cnt_inc == target_q);

   assign cfg_ok  = cfg_we && (state_q != RUN) && (cfg_len != '0) && (cfg_len <= LEN_MAX);
   // A start alongside a valid write arms with the freshly written length.
   assign eff_len = cfg_ok ? cfg_len : len_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, arm/launch decision and pulse requests.
   always_comb begin
      state_d   = state_q;
      launch    = 1'b0;
      done_d    = 1'b0;
      cfg_err_d = cfg_we && !cfg_ok;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (eff_len != '0) begin
                  state_d = RUN;
                  launch  = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            // stop wins over a match that would have completed the run
            if (stop) begin
               state_d = IDLE;
            end else if (match && hit_target) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               if (eff_len != '0) begin
                  state_d = RUN;
                  launch  = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Configuration registers, writable only outside RUN.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_q    <= '0;
         len_q    <= '0;
         ovl_q    <= 1'b0;
         target_q <= '0;
      end else if (cfg_ok) begin
         pat_q    <= cfg_pat;
         len_q    <= cfg_len;
         ovl_q    <= cfg_ovl;
         target_q <= cfg_target;
      end
   end

   // History, fill level and match counter; invalid cycles leave all of it untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q      <= '0;
         fill_q      <= '0;
         match_cnt_q <= '0;
      end else if (launch) begin
         hist_q      <= '0;
         fill_q      <= '0;
         match_cnt_q <= '0;
      end else if ((state_q == RUN) && in_valid) begin
         if (match) begin
            match_cnt_q <= cnt_inc;
            if (ovl_q) begin
               hist_q <= window;
               fill_q <= fill_inc;
            end else begin
               hist_q <= '0;
               fill_q <= '0;
            end
         end else begin
            hist_q <= window;
            fill_q <= fill_inc;
         end
      end
   end

   // One-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign match_cnt = match_cnt_q;
   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule
